// File: rtl/base58_ascii_decoder.sv
// base58_ascii_decoder: streaming base-58 ASCII digit decoder.
// Accepts one character per cycle, most-significant digit first, and accumulates
// acc*58 + d. It reports the binary value, or an error code, on a held
// valid/ready output. It is the inverse of the 8-bit-to-base-58 ASCII converter.
module base58_ascii_decoder #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_error,
  output logic [1:0]       out_err_code,
  output logic [3:0]       out_count
);

  localparam int EXT = WIDTH + 6;

  localparam logic [EXT-1:0] BASE58 = EXT'(58);
  localparam logic [3:0]     MAX_CNT = 4'(MAX_DIGITS);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_INVALID  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_TOO_MANY = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SKIP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] acc;
  logic [3:0]       count;
  logic [1:0]       err_code;

  logic             accept;
  logic [5:0]       digit;
  logic             digit_ok;
  logic [WIDTH-1:0] acc_base;
  logic [EXT-1:0]   acc_next;
  logic             overflow;
  logic [3:0]       count_next;
  logic [1:0]       err_next;

  // Map an ASCII character onto its base-58 digit value. The low six bits of
  // each alphabet range differ from the digit value by a fixed offset, so a
  // 6-bit add is enough once the full byte has been range-checked.
  always_comb begin
    digit    = 6'd0;
    digit_ok = 1'b0;
    if (in_char >= 8'd48 && in_char <= 8'd57) begin
      digit    = in_char[5:0] - 6'd48;
      digit_ok = 1'b1;
    end else if (in_char >= 8'd65 && in_char <= 8'd90) begin
      digit    = in_char[5:0] + 6'd9;
      digit_ok = 1'b1;
    end else if (in_char >= 8'd97 && in_char <= 8'd118) begin
      digit    = in_char[5:0] + 6'd3;
      digit_ok = 1'b1;
    end
  end

  // Next accumulator, count and error code for the character on the input.
  // The first error of a frame sticks, and SKIP never adds new errors.
  always_comb begin
    accept     = in_valid && in_ready;
    acc_base   = (state == IDLE) ? '0 : acc;
    acc_next   = {6'd0, acc_base} * BASE58 + {{WIDTH{1'b0}}, digit};
    overflow   = |acc_next[EXT-1:WIDTH];
    count_next = (count == 4'd15) ? 4'd15 : count + 4'd1;
    err_next   = err_code;
    if (err_code == ERR_NONE && state != SKIP) begin
      if (!digit_ok) begin
        err_next = ERR_INVALID;
      end else if (overflow) begin
        err_next = ERR_OVERFLOW;
      end else if (count_next > MAX_CNT) begin
        err_next = ERR_TOO_MANY;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and in_ready, which is decoded from the state and rst only.
  always_comb begin
    state_next = state;
    in_ready   = !rst && (state != DONE);
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          if (in_last) begin
            state_next = DONE;
          end else if (err_next != ERR_NONE) begin
            state_next = SKIP;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      SKIP: begin
        if (accept && in_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame bookkeeping and the registered result. The result is captured on
  // the final accept and then held until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      count        <= 4'd0;
      err_code     <= ERR_NONE;
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_error    <= 1'b0;
      out_err_code <= ERR_NONE;
      out_count    <= 4'd0;
    end else if (state == DONE) begin
      if (out_ready) begin
        out_valid <= 1'b0;
        acc       <= '0;
        count     <= 4'd0;
        err_code  <= ERR_NONE;
      end
    end else if (accept) begin
      if (state != SKIP) begin
        acc <= acc_next[WIDTH-1:0];
      end
      count    <= count_next;
      err_code <= err_next;
      if (in_last) begin
        out_valid    <= 1'b1;
        out_count    <= count_next;
        out_err_code <= err_next;
        out_error    <= (err_next != ERR_NONE);
        out_value    <= (err_next != ERR_NONE) ? '0 : acc_next[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_base58_ascii_decoder.sv
// tb_base58_ascii_decoder: directed bench for base58_ascii_decoder.
// An 8-bit and a 16-bit instance receive the same character stream and stay
// in lockstep, so each frame checks both widths against hand-computed results.
module tb_base58_ascii_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_last;
  logic        out_ready;

  logic        in_ready8, out_valid8, out_error8;
  logic [7:0]  out_value8;
  logic [1:0]  out_err_code8;
  logic [3:0]  out_count8;

  logic        in_ready16, out_valid16, out_error16;
  logic [15:0] out_value16;
  logic [1:0]  out_err_code16;
  logic [3:0]  out_count16;

  int checkCount;
  int passCount;

  base58_ascii_decoder #(.WIDTH(8), .MAX_DIGITS(3)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready8),
    .in_char      (in_char),
    .in_last      (in_last),
    .out_valid    (out_valid8),
    .out_ready    (out_ready),
    .out_value    (out_value8),
    .out_error    (out_error8),
    .out_err_code (out_err_code8),
    .out_count    (out_count8)
  );

  base58_ascii_decoder #(.WIDTH(16), .MAX_DIGITS(3)) dut16 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready16),
    .in_char      (in_char),
    .in_last      (in_last),
    .out_valid    (out_valid16),
    .out_ready    (out_ready),
    .out_value    (out_value16),
    .out_error    (out_error16),
    .out_err_code (out_err_code16),
    .out_count    (out_count16)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present one character and wait (bounded) for it to be accepted.
  // Called and returns 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] c, input logic last);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    while (!in_ready8 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready8) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendFrame(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i], (i == s.len() - 1));
      if (gap > 0 && i != s.len() - 1) idleCycles(gap);
    end
  endtask

  // Check the result one cycle after the last accept, then take it and
  // check the return to IDLE with in_ready high on the following cycle.
  task automatic expectFrame(input string tag,
                             input logic [31:0] v8, input logic [1:0] e8,
                             input logic [31:0] v16, input logic [1:0] e16,
                             input logic [3:0] cnt);
    checkOutput({tag, "_valid8"}, out_valid8, 1);
    checkOutput({tag, "_valid16"}, out_valid16, 1);
    checkOutput({tag, "_ready_done"}, in_ready8, 0);
    checkOutput({tag, "_value8"}, out_value8, v8);
    checkOutput({tag, "_code8"}, out_err_code8, e8);
    checkOutput({tag, "_error8"}, out_error8, (e8 != 2'b00));
    checkOutput({tag, "_count8"}, out_count8, cnt);
    checkOutput({tag, "_value16"}, out_value16, v16);
    checkOutput({tag, "_code16"}, out_err_code16, e16);
    checkOutput({tag, "_error16"}, out_error16, (e16 != 2'b00));
    checkOutput({tag, "_count16"}, out_count16, cnt);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_drop8"}, out_valid8, 0);
    checkOutput({tag, "_drop16"}, out_valid16, 0);
    checkOutput({tag, "_idle_ready8"}, in_ready8, 1);
    checkOutput({tag, "_idle_ready16"}, in_ready16, 1);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_char    = 8'd0;
    in_last    = 1'b0;
    out_ready  = 1'b0;

    // Reset values
    #2;
    checkOutput("rst_ready", in_ready8, 0);
    checkOutput("rst_valid", out_valid16, 0);
    checkOutput("rst_count", out_count16, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("release_ready8", in_ready8, 1);
    checkOutput("release_ready16", in_ready16, 1);
    @(posedge clk);
    #1;

    // "04N" = 4*58 + 23 = 255, the largest 8-bit value; check latency too
    applyStimulus("0", 1'b0);
    applyStimulus("4", 1'b0);
    checkOutput("pre_last_valid", out_valid8, 0);
    applyStimulus("N", 1'b1);
    expectFrame("max8", 255, 2'b00, 255, 2'b00, 4'd3);

    // "04O" = 256: overflow at 8 bits, fine at 16 bits
    sendFrame("04O", 0);
    expectFrame("ovf", 0, 2'b10, 256, 2'b00, 4'd3);

    // "1w2": 'w' is invalid, block sits in SKIP (encoding 2) until '2'
    applyStimulus("1", 1'b0);
    applyStimulus("w", 1'b0);
    checkOutput("skip_state8", 32'(dut8.state), 2);
    checkOutput("skip_state16", 32'(dut16.state), 2);
    applyStimulus("2", 1'b1);
    expectFrame("inval", 0, 2'b01, 0, 2'b01, 4'd3);

    // "vv" = 57*58 + 57 = 3363; overflows the 8-bit instance
    sendFrame("vv", 0);
    expectFrame("vv", 0, 2'b10, 3363, 2'b00, 4'd2);

    // "0001": fourth digit exceeds MAX_DIGITS
    sendFrame("0001", 0);
    expectFrame("toomany", 0, 2'b11, 0, 2'b11, 4'd4);

    // Byte 0xB0 shares its low bits with '0' but is invalid
    applyStimulus(8'hB0, 1'b1);
    expectFrame("high_byte", 0, 2'b01, 0, 2'b01, 4'd1);

    // Backpressure: "Z" = 35 held for 10 cycles with out_ready low
    applyStimulus("Z", 1'b1);
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_value", out_value16, 35);
      checkOutput("bp_valid", out_valid16, 1);
      checkOutput("bp_ready", in_ready16, 0);
      @(posedge clk);
      #1;
    end
    expectFrame("bp", 35, 2'b00, 35, 2'b00, 4'd1);

    // Gaps inside a frame do not change the result
    sendFrame("04N", 2);
    expectFrame("gaps", 255, 2'b00, 255, 2'b00, 4'd3);

    // Reset mid-frame: outputs (still holding the last frame) clear at once
    applyStimulus("0", 1'b0);
    applyStimulus("4", 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_value8", out_value8, 0);
    checkOutput("mid_rst_value16", out_value16, 0);
    checkOutput("mid_rst_count", out_count16, 0);
    checkOutput("mid_rst_ready", in_ready16, 0);
    idleCycles(2);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    idleCycles(3);
    checkOutput("no_out_after_rst", out_valid16, 0);
    sendFrame("a", 0);
    expectFrame("after_rst", 36, 2'b00, 36, 2'b00, 4'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/base58_ascii_decoder.md
# base58_ascii_decoder

Streaming decoder that turns a frame of base-58 ASCII digit characters back into a binary value. It is the inverse of the team's 8-bit-to-base-58 ASCII converter and uses the same alphabet. Characters arrive one per cycle on a valid/ready input, most-significant digit first, with an end-of-frame marker. The decoded value, or an error code, is presented on a valid/ready output.

## Interface
- `WIDTH`, default 16: width of the decoded value and of the accumulator; minimum 6.
- `MAX_DIGITS`, default 3: maximum number of characters per frame, 1..15.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_char` and `in_last` are valid.
- `in_ready` output 1: decoder can accept a character this cycle.
- `in_char` input 8: ASCII character.
- `in_last` input 1: this character is the final one in the frame.
- `out_valid` output 1: a decode result is held on the output.
- `out_ready` input 1: the consumer accepts the result.
- `out_value` output WIDTH: decoded value; forced to 0 when `out_error` is 1.
- `out_error` output 1: the frame was rejected.
- `out_err_code` output 2: 00 none, 01 invalid character, 10 overflow, 11 too many digits.
- `out_count` output 4: number of characters consumed in the frame, saturating at 15.

## Operation
- **Alphabet:** a character maps to one digit value `d` as follows.
  - '0'..'9' (48..57) map to 0..9.
  - 'A'..'Z' (65..90) map to 10..35.
  - 'a'..'v' (97..118) map to 36..57.
  - Every other code is invalid, including 'w'..'z', punctuation and bytes of 128 or more.
- **Accept:** a character is accepted on a cycle where `in_valid` and `in_ready` are both 1.
- **States:** IDLE, ACCUM, SKIP, DONE.
  - `in_ready` is 1 in IDLE, ACCUM and SKIP.
  - `in_ready` is 0 in DONE and while `rst` is asserted.
- **IDLE or ACCUM, on accept:**
  - Update the accumulator: acc_next = acc*58 + d, computed at WIDTH+6 bits.
  - Increment the count.
  - acc is taken as 0 for the first character of a frame.
- **Error detection, first error wins:**
  - Invalid character gives code 01.
  - Any nonzero bit of acc_next above bit WIDTH-1 gives code 10.
  - A count greater than MAX_DIGITS gives code 11.
  - Once the error code is set, later errors in the same frame do not change it.
- **Transitions on accept:**
  - With `in_last`=1, go to DONE.
  - With `in_last`=0 and no error yet, go to (or stay in) ACCUM.
  - With `in_last`=0 and an error, go to SKIP.
- **SKIP:** accepted characters are discarded apart from incrementing the count. Go to DONE on the accept that has `in_last`=1.
- **DONE:**
  - `out_valid`=1; `out_value`, `out_error`, `out_err_code` and `out_count` are held stable.
  - When `out_ready`=1, go to IDLE and clear the accumulator, count and error fields.
- **Empty frames:** none exist; every frame contains at least one character.

## Timing
- **Reset:** while `rst`=1, and immediately on assertion, the following hold.
  - State is IDLE and `in_ready`=0.
  - `out_valid`=0, `out_value`=0, `out_error`=0, `out_err_code`=00, `out_count`=0.
  - The accumulator is cleared.
- **After reset release:** `in_ready`=1 from the first cycle onward.
- **Reset mid-frame or mid-DONE:** the partial frame is discarded and no output is produced for it.
- **Throughput:** one character per cycle inside a frame; stalls on `in_valid` gaps are allowed in any state.
- **Latency:** `out_valid` rises the cycle after the accept that carried `in_last`=1.
- **Backpressure:** with `out_ready`=0, DONE and all outputs hold indefinitely and `in_ready` stays 0.
- **Frame spacing:** a handshake at edge N returns the block to IDLE. `in_ready`=1 in cycle N+1, so there is a one-cycle bubble between frames.
- **Output hold in IDLE:** `out_valid` drops after the handshake; the other outputs keep their last values but are meaningless while `out_valid`=0.
- **Output timing:** all outputs except `in_ready` are registered. `in_ready` is decoded from the state register and `rst` only, never from `in_valid` or `out_ready`.

## Test plan
- **Maximum 8-bit value:** WIDTH=8, MAX_DIGITS=3, send "04N" back-to-back with `in_last` on 'N'. Required: `out_value`=255, `out_error`=0, `out_count`=3, one cycle after 'N'.
- **Overflow:** WIDTH=8, send "04O". Required: `out_error`=1, `out_err_code`=10, `out_value`=0, `out_count`=3.
- **Invalid character:** WIDTH=16, send "1w2" with `in_last` on '2'. Required: the block is in SKIP after 'w'; `out_err_code`=01, `out_count`=3. Then send "vv": `out_value`=3363, no error.
- **Too many digits:** WIDTH=16, MAX_DIGITS=3, send "0001". Required: `out_err_code`=11, `out_count`=4.
- **Backpressure and gaps:** hold `out_ready`=0 for 10 cycles after "Z". Required: `out_value`=35 is held stable and `in_ready`=0 throughout. Raise `out_ready`: IDLE follows and `in_ready`=1 on the next cycle. Insert `in_valid` gaps within a frame and check the result is unchanged.
- **Reset mid-frame:** assert `rst` asynchronously after "04". Required: all outputs 0 at once and no `out_valid`. After release, "a" decodes to 36.
